// File: rtl/button_debounce_pkg.sv
// Shared definitions for the button debouncer: FSM encodings and counter width helper.
package button_debounce_pkg;

    typedef logic [0:0] db_state_t;

    localparam db_state_t STABLE  = 1'b0;
    localparam db_state_t PENDING = 1'b1;

    // Bits needed to hold 0..n inclusive; never less than one bit.
    function automatic int cnt_width(input int n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction

endpackage

// File: rtl/sync_1bit.sv
// Parameterised-depth single-bit synchroniser with a configurable reset value.
module sync_1bit #(
    parameter int STAGES      = 2,
    parameter bit RESET_LEVEL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] chain;

    always_ff @(posedge clk) begin
        if (rst) chain <= {STAGES{RESET_LEVEL}};
        else     chain <= {chain[STAGES-2:0], d};
    end

    assign q = chain[STAGES-1];

endmodule

// File: rtl/button_debounce.sv
// Debounced button level with press/release strobes.
// Optional long-press strobe enabled by defining BUTTON_DEBOUNCE_LONGPRESS_EN.
module button_debounce
    import button_debounce_pkg::*;
#(
    parameter int SYNC_STAGES      = 2,
    parameter int DEBOUNCE_CYCLES  = 1000,
    parameter bit RESET_LEVEL      = 1'b0,
    parameter int LONGPRESS_CYCLES = 1048576
) (
    input  logic clk,
    input  logic rst,
    input  logic in,
    output logic level,
    output logic rise,
    output logic fall,
    output logic longpress
);

    localparam int             DW      = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [DW-1:0]  DEB_MAX = DW'(DEBOUNCE_CYCLES);

    if (SYNC_STAGES < 2 || SYNC_STAGES > 4 || DEBOUNCE_CYCLES < 1 || LONGPRESS_CYCLES < 1)
    begin : g_bad_param
        $error("button_debounce: parameter out of legal range");
    end

    logic          s;
    db_state_t     state;
    logic [DW-1:0] cnt;

    sync_1bit #(
        .STAGES     (SYNC_STAGES),
        .RESET_LEVEL(RESET_LEVEL)
    ) u_sync (
        .clk(clk),
        .rst(rst),
        .d  (in),
        .q  (s)
    );

    // The counter only runs in PENDING and is cleared on every exit, so it never wraps.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= STABLE;
            cnt   <= '0;
            level <= RESET_LEVEL;
            rise  <= 1'b0;
            fall  <= 1'b0;
        end else begin
            rise <= 1'b0;
            fall <= 1'b0;
            case (state)
                STABLE: begin
                    if (s != level) begin
                        state <= PENDING;
                        cnt   <= DW'(1);
                    end
                end
                PENDING: begin
                    if (s == level) begin
                        state <= STABLE;
                        cnt   <= '0;
                    end else if (cnt == DEB_MAX) begin
                        state <= STABLE;
                        cnt   <= '0;
                        level <= s;
                        rise  <= s;
                        fall  <= ~s;
                    end else begin
                        cnt <= cnt + DW'(1);
                    end
                end
                default: begin
                    state <= STABLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

`ifdef BUTTON_DEBOUNCE_LONGPRESS_EN
    localparam int            LW     = cnt_width(LONGPRESS_CYCLES);
    localparam logic [LW-1:0] LP_MAX = LW'(LONGPRESS_CYCLES);
    localparam logic [LW-1:0] LP_PRE = LW'(LONGPRESS_CYCLES - 1);

    logic [LW-1:0] lp_cnt;

    // Saturates at LP_MAX so the strobe fires once per press.
    always_ff @(posedge clk) begin
        if (rst) begin
            lp_cnt    <= '0;
            longpress <= 1'b0;
        end else begin
            longpress <= 1'b0;
            if (!level) begin
                lp_cnt <= '0;
            end else if (lp_cnt != LP_MAX) begin
                lp_cnt    <= lp_cnt + LW'(1);
                longpress <= (lp_cnt == LP_PRE);
            end
        end
    end
`else
    assign longpress = 1'b0;
`endif

endmodule

// File: tb/tb_button_debounce.sv
// Self-checking bench: three debouncer configurations against a run-length reference model.
module tb_button_debounce;

    logic clk = 1'b0;
    always #5 clk = ~clk;

`ifdef BUTTON_DEBOUNCE_LONGPRESS_EN
    localparam bit LP_EN = 1'b1;
`else
    localparam bit LP_EN = 1'b0;
`endif

    logic din[3], drst[3];
    logic lvl_o[3], rise_o[3], fall_o[3], lp_o[3];

    int checks = 0, failures = 0, cyc = 0;

    // per-instance configuration: sync depth, debounce cycles, reset level, long-press cycles
    int ss[3] = '{2, 3, 4};
    int dc[3] = '{4, 1, 3};
    bit rl[3] = '{1'b0, 1'b0, 1'b1};
    int ll[3] = '{16, 8, 5};

    button_debounce #(.SYNC_STAGES(2), .DEBOUNCE_CYCLES(4), .RESET_LEVEL(1'b0), .LONGPRESS_CYCLES(16)) u_a (
        .clk(clk), .rst(drst[0]), .in(din[0]), .level(lvl_o[0]), .rise(rise_o[0]), .fall(fall_o[0]), .longpress(lp_o[0]));
    button_debounce #(.SYNC_STAGES(3), .DEBOUNCE_CYCLES(1), .RESET_LEVEL(1'b0), .LONGPRESS_CYCLES(8)) u_b (
        .clk(clk), .rst(drst[1]), .in(din[1]), .level(lvl_o[1]), .rise(rise_o[1]), .fall(fall_o[1]), .longpress(lp_o[1]));
    button_debounce #(.SYNC_STAGES(4), .DEBOUNCE_CYCLES(3), .RESET_LEVEL(1'b1), .LONGPRESS_CYCLES(5)) u_c (
        .clk(clk), .rst(drst[2]), .in(din[2]), .level(lvl_o[2]), .rise(rise_o[2]), .fall(fall_o[2]), .longpress(lp_o[2]));

    // Reference: sampled history of `in`; level flips once the delayed sample has
    // disagreed with it for DEBOUNCE_CYCLES+1 consecutive edges.
    bit sy[3][4];
    bit mlvl[3], erise[3], efall[3], elp[3];
    int run[3], lpr[3];

    task automatic model_edge(input int k);
        bit s, l;
        if (drst[k]) begin
            for (int j = 0; j < 4; j++) sy[k][j] = rl[k];
            mlvl[k] = rl[k]; run[k] = 0; lpr[k] = 0;
            erise[k] = 0; efall[k] = 0; elp[k] = 0;
        end else begin
            s = sy[k][ss[k]-1];
            l = mlvl[k];
            erise[k] = 0; efall[k] = 0; elp[k] = 0;
            if (l) begin
                if (lpr[k] < ll[k]) begin
                    lpr[k]++;
                    if (lpr[k] == ll[k]) elp[k] = LP_EN;
                end
            end else lpr[k] = 0;
            if (s != l) begin
                run[k]++;
                if (run[k] == dc[k] + 1) begin
                    mlvl[k] = s; erise[k] = s; efall[k] = !s; run[k] = 0;
                end
            end else run[k] = 0;
            for (int j = 3; j > 0; j--) sy[k][j] = sy[k][j-1];
            sy[k][0] = din[k];
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s cyc=%0d observed=%0d expected=%0d", tag, cyc, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        for (int k = 0; k < 3; k++) model_edge(k);
        cyc++;
        #1;
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("dut%0d_level", k), 32'(lvl_o[k]), 32'(mlvl[k]));
            chk($sformatf("dut%0d_rise", k),  32'(rise_o[k]), 32'(erise[k]));
            chk($sformatf("dut%0d_fall", k),  32'(fall_o[k]), 32'(efall[k]));
            chk($sformatf("dut%0d_longpress", k), 32'(lp_o[k]), 32'(elp[k]));
        end
    endtask

    int rise_at, lp_at, lp_n, strobes, hold[3];

    initial begin
        din[0] = 0; din[1] = 0; din[2] = 1;
        for (int k = 0; k < 3; k++) drst[k] = 1;
        repeat (3) tick();
        for (int k = 0; k < 3; k++) drst[k] = 0;

        // quiet after reset
        strobes = 0;
        repeat (20) begin
            tick();
            strobes += int'(rise_o[0]) + int'(fall_o[0]) + int'(lp_o[0]);
        end
        chk("reset_level", 32'(lvl_o[0]), 32'd0);
        chk("reset_strobes", 32'(strobes), 32'd0);

        // bounce: high 3, low 2, high 3, low held
        strobes = 0;
        din[0] = 1; repeat (3) tick();
        din[0] = 0; repeat (2) tick();
        din[0] = 1; repeat (3) tick();
        din[0] = 0;
        repeat (20) begin
            tick();
            strobes += int'(rise_o[0]) + int'(fall_o[0]) + int'(lvl_o[0]);
        end
        chk("bounce_quiet", 32'(strobes), 32'd0);

        // clean press: level changes on the 7th edge after the step
        din[0] = 1;
        repeat (6) tick();
        chk("press_early_level", 32'(lvl_o[0]), 32'd0);
        tick();
        chk("press_level", 32'(lvl_o[0]), 32'd1);
        chk("press_rise", 32'(rise_o[0]), 32'd1);
        tick();
        chk("press_rise_one_cycle", 32'(rise_o[0]), 32'd0);
        repeat (10) tick();

        // clean release
        din[0] = 0;
        repeat (6) tick();
        chk("release_early_fall", 32'(fall_o[0]), 32'd0);
        tick();
        chk("release_fall", 32'(fall_o[0]), 32'd1);
        chk("release_level", 32'(lvl_o[0]), 32'd0);
        repeat (10) tick();

        // reset mid-PENDING
        din[0] = 1;
        repeat (4) tick();
        drst[0] = 1; din[0] = 0;
        tick();
        drst[0] = 0;
        strobes = 0;
        repeat (15) begin
            tick();
            strobes += int'(rise_o[0]) + int'(lvl_o[0]);
        end
        chk("rst_mid_pending", 32'(strobes), 32'd0);

        // long press, twice
        lp_n = 0; rise_at = -1; lp_at = -1;
        for (int p = 0; p < 2; p++) begin
            din[0] = 1;
            repeat (40) begin
                tick();
                if (rise_o[0]) rise_at = cyc;
                if (lp_o[0]) begin lp_n++; lp_at = cyc; end
            end
            if (p == 0) chk("longpress_delay", 32'(lp_at - rise_at), LP_EN ? 32'd16 : 32'hFFFF_FFFF & 32'(-1 - rise_at));
            din[0] = 0;
            repeat (20) tick();
        end
        chk("longpress_count", 32'(lp_n), LP_EN ? 32'd2 : 32'd0);

        // DEBOUNCE_CYCLES=1: single-cycle pulse rejected
        strobes = 0;
        din[1] = 1; tick();
        din[1] = 0;
        repeat (10) begin
            tick();
            strobes += int'(rise_o[1]) + int'(lvl_o[1]);
        end
        chk("b_pulse1_rejected", 32'(strobes), 32'd0);

        // two-cycle pulse: rise on edge 4, fall two edges later
        din[1] = 1; tick(); tick();
        din[1] = 0; tick(); tick();
        chk("b_pulse2_pre", 32'(rise_o[1]), 32'd0);
        tick();
        chk("b_pulse2_rise", 32'(rise_o[1]), 32'd1);
        tick();
        chk("b_pulse2_gap", 32'(fall_o[1]), 32'd0);
        tick();
        chk("b_pulse2_fall", 32'(fall_o[1]), 32'd1);
        repeat (10) tick();

        // randomized phase
        for (int k = 0; k < 3; k++) hold[k] = 0;
        repeat (3000) begin
            for (int k = 0; k < 3; k++) begin
                if (hold[k] == 0) begin
                    din[k] = ~din[k];
                    hold[k] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(10, 40))
                                                          : int'($urandom_range(1, 6));
                end else hold[k]--;
                drst[k] = ($urandom_range(0, 299) == 0);
            end
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/button_debounce.md
Name: button_debounce

Overview:
- Consumes the raw, asynchronous, already-inverted logic level from a pad input buffer, e.g. a pulled-up button or switch where pressed = 1.
- Synchronises the level into the `clk` domain and rejects bounce by requiring it to be stable for a programmable number of cycles.
- Presents a clean level plus single-cycle press/release strobes to downstream logic (GPIO registers, menu FSMs, reset requesters).

Parameters:
- SYNC_STAGES, 2: synchroniser flop count. Legal range 2..4.
- DEBOUNCE_CYCLES, 1000: consecutive cycles the synchronised input must differ from `level` before `level` updates. Legal range ≥ 1.
- RESET_LEVEL, 0: value of the synchroniser flops and `level` during and after reset.
- LONGPRESS_CYCLES, 1048576: cycles `level` must stay 1 before `longpress` fires. Only used with BUTTON_DEBOUNCE_LONGPRESS_EN. Legal range ≥ 1.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous, active-high reset
- in  input  1  asynchronous raw level from the pad buffer
- level  output  1  debounced, synchronised level
- rise  output  1  one-cycle strobe on `level` 0→1
- fall  output  1  one-cycle strobe on `level` 1→0
- longpress  output  1  one-cycle strobe after a sustained high; tied 0 without the macro

Behaviour:
- Interface: one clock, `clk`; reset `rst` is synchronous and active-high. All state updates on the rising edge of `clk`. While `rst` is high at an edge, all state loads its reset value.
- Reset values:
  - synchroniser flops = RESET_LEVEL
  - `level` = RESET_LEVEL
  - `rise` = `fall` = `longpress` = 0
  - debounce counter = 0
  - long-press counter = 0
  - FSM = STABLE
- No strobe fires on the first cycle after reset; the synchroniser and `level` start equal.
- Synchroniser: SYNC_STAGES-flop shift chain on `in`. Call the last stage `s`. This is the only logic that samples `in`.
- Debounce counter: width $clog2(DEBOUNCE_CYCLES+1).
- FSM, two states:
  - STABLE: `s == level`, counter held at 0. On `s != level`, go to PENDING and set counter = 1.
  - PENDING, `s == level`: counter = 0, go to STABLE. A glitch is discarded with no output activity.
  - PENDING, `s != level` and counter == DEBOUNCE_CYCLES: `level <= s`, counter = 0, go to STABLE. In the same edge, `rise <= s` and `fall <= ~s`.
  - PENDING, `s != level` otherwise: counter increments.
- DEBOUNCE_CYCLES = 1: `level` follows `s` one edge after the mismatch is first seen.
- Latency: a clean step on `in`, settled before edge 0, appears on `level` after SYNC_STAGES + DEBOUNCE_CYCLES + 1 edges. `rise`/`fall` assert in the same cycle `level` changes.
- Strobes are high for exactly one cycle and are never simultaneous. The counter never wraps: it is reset on the terminal condition.
- An input toggle arriving while in PENDING, returning to match `level`, restarts qualification from STABLE.
- Reset mid-PENDING: the pending change is abandoned and no strobe fires.

Optional Feature:
- Macro: BUTTON_DEBOUNCE_LONGPRESS_EN.
- Defined:
  - 21-bit saturating long-press counter, width $clog2(LONGPRESS_CYCLES+1).
  - Cleared whenever `level` == 0. Increments each cycle `level` == 1 until it reaches LONGPRESS_CYCLES, then holds.
  - `longpress` pulses for one cycle on the edge the counter first reaches LONGPRESS_CYCLES.
  - No repeat until `level` falls and rises again.
  - A release fires `fall` as normal.
- Undefined: no counter is instantiated and `longpress` is constant 0.

Decomposition:
- Shared package/header `button_debounce_pkg`:
  - FSM state encodings (STABLE = 1'b0, PENDING = 1'b1)
  - localparam width helpers for the counter widths
- One natural sub-module, `sync_1bit`: parameterised-depth flop chain with reset value RESET_LEVEL. It is reusable by other async-input blocks.

Test Plan:
- Reset: SYNC_STAGES=2, DEBOUNCE_CYCLES=4, RESET_LEVEL=0, `in`=0. Hold `rst` 3 cycles, release → `level`=0 and `rise`/`fall`/`longpress` all 0 for 20 cycles.
- Clean press: `in` 0→1 before edge 0, held → `level`=1 from edge 7. `rise`=1 for exactly that one cycle, `fall` stays 0.
- Bounce: `in` high 3 cycles, low 2, high 3, low held → `level` never leaves 0 and no strobes fire.
- Clean release, then reset mid-PENDING: from `level`=1, `in`→0 → `fall` fires one cycle, 7 edges later. Repeat the press and assert `rst` at edge 4 → `level`=0, no `rise`.
- Long press (macro defined, LONGPRESS_CYCLES=16): hold `in`=1 for 40 cycles → `longpress` pulses once, 16 edges after `rise`. Release and re-press → second pulse. Without the macro → `longpress` always 0.
- Edge case, DEBOUNCE_CYCLES=1, SYNC_STAGES=3: 1-cycle `in` pulse is rejected. 2-cycle pulse → `rise` at edge 4, then `fall` 2 cycles later.
